add: RTL and testbench
======================

ADD -- requirements
Module: add

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; legal range 1..32.
REQ-002 Parameter LATENCY, default 1, clock cycles from operand sample to result; legal values 1 or 2.
REQ-003 Port clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 Port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port a  input  WIDTH  operand A, unsigned.
REQ-006 Port b  input  WIDTH  operand B, unsigned.
REQ-007 Port sub  input  1  operation select: 0 = add, 1 = subtract; tie-off default 0.
REQ-008 Port sum  output  WIDTH+1  registered result; MSB is carry (add) or borrow (sub).
REQ-009 Port zero  output  1  registered flag, high when sum[WIDTH-1:0] == 0.
REQ-010 Port carry_cnt  output  16  count of results with MSB set; present only when ADD_STATS_EN is defined.

Function
REQ-011 Add mode SHALL compute sum = a + b, zero-extended to WIDTH+1 bits, with no truncation.
REQ-012 Sub mode SHALL compute sum = {1'b0,a} - {1'b0,b} modulo 2^(WIDTH+1); MSB = 1 when a < b.
REQ-013 a, b and sub SHALL be sampled together on every rising clk edge; there is no enable or handshake.
REQ-014 With LATENCY=1, sum and zero SHALL reflect the operands sampled at edge N, valid after edge N.
REQ-015 With LATENCY=2, results SHALL appear one edge later than with LATENCY=1; operands are registered first, then the result.
REQ-016 Operand changes between edges SHALL NOT affect the outputs; the outputs hold their value until the next edge.
REQ-017 zero and sum SHALL always describe the same operation and never be skewed by a cycle.
REQ-018 No combinational path SHALL exist from any input to any output.

Reset
REQ-019 rst_n low SHALL immediately clear sum to 0, set zero to 1, clear all pipeline registers, and clear carry_cnt, independent of clk.
REQ-020 Reset asserted mid-operation SHALL discard every in-flight result.
REQ-021 After rst_n deasserts, the first result SHALL appear LATENCY edges after the first rising edge.

Configuration
REQ-022 Macro ADD_STATS_EN: when defined, carry_cnt SHALL increment by 1 on each edge that registers a result with MSB = 1, and SHALL saturate at 16'hFFFF.
REQ-023 Without ADD_STATS_EN, the carry_cnt port and its counter SHALL be absent, and all other behaviour is unchanged.

Structure
REQ-024 Package add_pkg SHALL hold DEFAULT_WIDTH = 4, the op_e enum (OP_ADD = 0, OP_SUB = 1) and CNT_W = 16.
REQ-025 Sub-module add_pipe_reg SHALL be the parameterised-width register with async active-low clear, instantiated once per pipeline stage.
REQ-026 Interface add_if SHALL bundle a, b, sum, sub, zero, clk and rst_n for bench connection.

Verification
REQ-027 Add: a = 1, b = 5, sub = 0 -> sum = 6 and zero = 0 after the next rising edge; then a = 3 -> sum = 8 one edge later.
REQ-028 Max values: a = 15, b = 15 -> sum = 5'b11110 (30); a = 0, b = 0 -> zero = 1.
REQ-029 Sub: a = 3, b = 5, sub = 1 -> sum = 5'b11110 (borrow set); a = 5, b = 5 -> sum = 0 and zero = 1.
REQ-030 Mid-cycle change: a toggles 4 -> 5 within 8 ns between edges -> sum shows only the value sampled at the edge.
REQ-031 Reset: rst_n driven low 3 ns after an edge -> sum = 0 and zero = 1 immediately; the first result returns LATENCY edges after release.
REQ-032 With LATENCY = 2 and ADD_STATS_EN: three back-to-back carry results -> sum lags by 2 edges and carry_cnt = 3.

Source files
------------

// File: rtl/add_pkg.sv
// Shared constants and types for the add block: default operand width,
// operation encoding and statistics counter width.
package add_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam int CNT_W         = 16;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

endpackage

// File: rtl/add_if.sv
// Signal bundle for connecting a bench or parent block to add.
// clk and rst_n come in as ports; the data signals are plain nets.
interface add_if #(
  parameter int WIDTH = add_pkg::DEFAULT_WIDTH
) (
  input logic clk,
  input logic rst_n
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic [WIDTH:0]   sum;
  logic             zero;

endinterface

// File: rtl/add_pipe_reg.sv
// Width-parameterised pipeline register, one instance per stage.
// Async active-low clear loads RST_VAL; otherwise it captures d every rising edge.
module add_pipe_reg #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/add.sv
// Registered unsigned add/subtract with carry/borrow MSB and zero flag; LATENCY 1 or 2.
// Optional saturating count of MSB-set results when ADD_STATS_EN is defined.
module add
  import add_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH:0]   sum,
  output logic             zero
`ifdef ADD_STATS_EN
  ,
  output logic [CNT_W-1:0] carry_cnt
`endif
);

  localparam int OPW = 2 * WIDTH + 1;
  localparam int RSW = WIDTH + 2;

  logic [OPW-1:0]   op_q;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  op_e              op_s;
  logic [WIDTH:0]   res;
  logic             res_zero;
  logic [RSW-1:0]   res_q;

  // LATENCY=2 adds an operand stage; LATENCY=1 computes straight from the ports.
  generate
    if (LATENCY == 2) begin : g_op_stage
      add_pipe_reg #(
        .W       (OPW),
        .RST_VAL ({OPW{1'b0}})
      ) u_op_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({sub, a, b}),
        .q     (op_q)
      );
    end else begin : g_no_op_stage
      assign op_q = {sub, a, b};
    end
  endgenerate

  always_comb begin
    op_s     = op_e'(op_q[OPW-1]);
    a_s      = op_q[2*WIDTH-1:WIDTH];
    b_s      = op_q[WIDTH-1:0];
    res      = (op_s == OP_SUB) ? ({1'b0, a_s} - {1'b0, b_s})
                                : ({1'b0, a_s} + {1'b0, b_s});
    res_zero = (res[WIDTH-1:0] == '0);
  end

  // zero rides in the same register as sum so the two can never skew.
  add_pipe_reg #(
    .W       (RSW),
    .RST_VAL ({1'b1, {(WIDTH+1){1'b0}}})
  ) u_res_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .d     ({res_zero, res}),
    .q     (res_q)
  );

  assign sum  = res_q[WIDTH:0];
  assign zero = res_q[RSW-1];

`ifdef ADD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_cnt <= '0;
    end else if (res[WIDTH] && (carry_cnt != {CNT_W{1'b1}})) begin
      carry_cnt <= carry_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_add.sv
// Directed bench for add: a LATENCY=1 and a LATENCY=2 instance share the same operands.
// Vector table drives both; the LATENCY=2 instance is checked against the previous vector.
module tb_add;
  import add_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst_n;

  add_if #(.WIDTH(W)) bus (.clk(clk), .rst_n(rst_n));

  logic [W:0] sum2;
  logic       zero2;
`ifdef ADD_STATS_EN
  logic [15:0] cnt1;
  logic [15:0] cnt2;
`endif

  add #(.WIDTH(W), .LATENCY(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (bus.a),
    .b     (bus.b),
    .sub   (bus.sub),
    .sum   (bus.sum),
    .zero  (bus.zero)
`ifdef ADD_STATS_EN
    ,
    .carry_cnt (cnt1)
`endif
  );

  add #(.WIDTH(W), .LATENCY(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (bus.a),
    .b     (bus.b),
    .sub   (bus.sub),
    .sum   (sum2),
    .zero  (zero2)
`ifdef ADD_STATS_EN
    ,
    .carry_cnt (cnt2)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W:0]   s;
    logic         z;
  } vec_t;

  vec_t tv[11];
  vec_t seq[4];

  int n_chk  = 0;
  int n_fail = 0;
  int c1     = 0;
  int c2     = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.sub = sub;
  endtask

  task automatic chk_cnt(input string nm);
`ifdef ADD_STATS_EN
    chk({nm, "_cnt1"}, 32'(cnt1), 32'(c1));
    chk({nm, "_cnt2"}, 32'(cnt2), 32'(c2));
`else
    if (nm.len() == 0) $display("empty counter tag");
`endif
  endtask

  initial begin
    //             a      b      sub     sum      zero
    tv[0]  = '{4'd1,  4'd5,  OP_ADD, 5'd6,  1'b0};
    tv[1]  = '{4'd3,  4'd5,  OP_ADD, 5'd8,  1'b0};
    tv[2]  = '{4'd15, 4'd15, OP_ADD, 5'd30, 1'b0};
    tv[3]  = '{4'd0,  4'd0,  OP_ADD, 5'd0,  1'b1};
    tv[4]  = '{4'd3,  4'd5,  OP_SUB, 5'd30, 1'b0};
    tv[5]  = '{4'd5,  4'd5,  OP_SUB, 5'd0,  1'b1};
    tv[6]  = '{4'd15, 4'd1,  OP_ADD, 5'd16, 1'b1};
    tv[7]  = '{4'd0,  4'd1,  OP_SUB, 5'd31, 1'b0};
    tv[8]  = '{4'd8,  4'd8,  OP_ADD, 5'd16, 1'b1};
    tv[9]  = '{4'd15, 4'd0,  OP_SUB, 5'd15, 1'b0};
    tv[10] = '{4'd7,  4'd2,  OP_ADD, 5'd9,  1'b0};

    seq[0] = '{4'd15, 4'd15, OP_ADD, 5'd30, 1'b0};
    seq[1] = '{4'd8,  4'd8,  OP_ADD, 5'd16, 1'b1};
    seq[2] = '{4'd9,  4'd9,  OP_ADD, 5'd18, 1'b0};
    seq[3] = '{4'd0,  4'd0,  OP_ADD, 5'd0,  1'b1};

    rst_n = 1'b0;
    drive(4'd0, 4'd0, 1'b0);
    #12;
    chk("rst_sum1",  32'(bus.sum),  32'd0);
    chk("rst_zero1", 32'(bus.zero), 32'd1);
    chk("rst_sum2",  32'(sum2),     32'd0);
    chk("rst_zero2", 32'(zero2),    32'd1);
    chk_cnt("rst");
    rst_n = 1'b1;

    // Table: dut2 must show the previous vector's result (cleared operands for the first).
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].a, tv[i].b, tv[i].sub);
      tick();
      c1 += 32'(tv[i].s[W]);
      chk($sformatf("vec%0d_sum1", i),  32'(bus.sum),  32'(tv[i].s));
      chk($sformatf("vec%0d_zero1", i), 32'(bus.zero), 32'(tv[i].z));
      if (i > 0) begin
        c2 += 32'(tv[i-1].s[W]);
        chk($sformatf("vec%0d_sum2", i),  32'(sum2),  32'(tv[i-1].s));
        chk($sformatf("vec%0d_zero2", i), 32'(zero2), 32'(tv[i-1].z));
      end else begin
        chk("vec0_sum2",  32'(sum2),  32'd0);
        chk("vec0_zero2", 32'(zero2), 32'd1);
      end
      chk_cnt($sformatf("vec%0d", i));
    end

    // Operand change between edges: only the edge-sampled value may appear.
    drive(4'd4, 4'd1, 1'b0);
    tick();
    chk("mid_sum1", 32'(bus.sum), 32'd5);
    chk("mid_sum2", 32'(sum2),    32'd9);
    #1 bus.a = 4'd5;
    #4;
    chk("mid_hold1", 32'(bus.sum), 32'd5);
    chk("mid_hold2", 32'(sum2),    32'd9);
    tick();
    chk("mid_next1", 32'(bus.sum), 32'd6);
    chk("mid_next2", 32'(sum2),    32'd5);

    // Reset 3 ns after an edge with a carry result in flight in dut2.
    drive(4'd15, 4'd15, 1'b0);
    tick();
    chk("pre_rst_sum1", 32'(bus.sum), 32'd30);
    chk("pre_rst_sum2", 32'(sum2),    32'd6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sum1",  32'(bus.sum),  32'd0);
    chk("arst_zero1", 32'(bus.zero), 32'd1);
    chk("arst_sum2",  32'(sum2),     32'd0);
    chk("arst_zero2", 32'(zero2),    32'd1);
    c1 = 0;
    c2 = 0;
    chk_cnt("arst");
    drive(4'd2, 4'd3, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rel1_sum1",  32'(bus.sum), 32'd5);
    chk("rel1_sum2",  32'(sum2),    32'd0);
    chk("rel1_zero2", 32'(zero2),   32'd1);
    chk_cnt("rel1");
    tick();
    chk("rel2_sum2",  32'(sum2),    32'd5);
    chk("rel2_zero2", 32'(zero2),   32'd0);

    // Back-to-back carry results, then a flush vector.
    for (int i = 0; i < 4; i++) begin
      drive(seq[i].a, seq[i].b, seq[i].sub);
      tick();
      c1 += 32'(seq[i].s[W]);
      chk($sformatf("b2b%0d_sum1", i),  32'(bus.sum),  32'(seq[i].s));
      chk($sformatf("b2b%0d_zero1", i), 32'(bus.zero), 32'(seq[i].z));
      if (i > 0) begin
        c2 += 32'(seq[i-1].s[W]);
        chk($sformatf("b2b%0d_sum2", i),  32'(sum2),  32'(seq[i-1].s));
        chk($sformatf("b2b%0d_zero2", i), 32'(zero2), 32'(seq[i-1].z));
      end else begin
        chk("b2b0_sum2", 32'(sum2), 32'd5);
      end
      chk_cnt($sformatf("b2b%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
